// File: rtl/gol_row_stepper.sv
// rtl/gol_row_stepper.sv - one Game of Life generation, streamed row by row between two regfiles
// Reads the current board one row per cycle and writes each next-generation row one cycle later.
module gol_row_stepper #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [REGBITS-1:0] ra,
    input  logic [WIDTH-1:0]   rd,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic               busy,
    output logic               done,
    output logic [15:0]        gen_count
);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   prev, cur, rule_row;
    logic [REGBITS-1:0] r;

    logic [WIDTH+1:0]   prev_pad, cur_pad, next_pad;
    logic [3:0]         n;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Row N-1 wraps ra to address 0, which reads the hardwired-zero bottom border.
    always_comb begin
        state_next = state;
        ra         = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = FILL;
            FILL: begin
                ra         = REGBITS'(1);
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                ra   = r + REGBITS'(1);
                busy = 1'b1;
                if (r == '1) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Zero padding on both sides models the dead columns -1 and WIDTH.
    always_comb begin
        prev_pad = {1'b0, prev, 1'b0};
        cur_pad  = {1'b0, cur,  1'b0};
        next_pad = {1'b0, rd,   1'b0};
        rule_row = '0;
        n        = '0;
        for (int c = 0; c < WIDTH; c++) begin
            n = {3'b0, prev_pad[c]} + {3'b0, prev_pad[c+1]} + {3'b0, prev_pad[c+2]}
              + {3'b0, cur_pad[c]}                          + {3'b0, cur_pad[c+2]}
              + {3'b0, next_pad[c]} + {3'b0, next_pad[c+1]} + {3'b0, next_pad[c+2]};
            rule_row[c] = (n == 4'd3) | (cur_pad[c+1] & (n == 4'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite  <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            prev      <= '0;
            cur       <= '0;
            r         <= '0;
            gen_count <= '0;
        end else begin
            regwrite <= 1'b0;
            case (state)
                IDLE: if (start) prev <= '0;
                FILL: begin
                    cur <= rd;
                    r   <= REGBITS'(1);
                end
                RUN: begin
                    regwrite <= 1'b1;
                    wa       <= r;
                    wd       <= rule_row;
                    prev     <= cur;
                    cur      <= rd;
                    if (r != '1) r <= r + REGBITS'(1);
                end
                DONE: gen_count <= gen_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gol_row_stepper.sv
// tb/tb_gol_row_stepper.sv - scoreboard bench for gol_row_stepper
// Stimulus pushes expected writes/done pulses; a negedge monitor pops and compares them.
module tb_gol_row_stepper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] ra;
    logic [7:0] rd;
    logic       regwrite;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       busy;
    logic       done;
    logic [15:0] gen_count;

    typedef struct {
        int         cyc;
        logic [2:0] wa;
        logic [7:0] wd;
    } wexp_t;

    wexp_t      wq[$];
    int         dq[$];
    logic [7:0] board [8];
    logic [7:0] expv  [8];
    logic [7:0] nxt   [8];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         exp_gen = 0;

    gol_row_stepper #(.WIDTH(8), .REGBITS(3)) dut (
        .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
        .regwrite(regwrite), .wa(wa), .wd(wd), .busy(busy), .done(done),
        .gen_count(gen_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Current-state regfile model: row 0 hardwired to zero, combinational read.
    assign rd = (ra == 3'd0) ? 8'h00 : board[ra];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (regwrite === 1'b1) begin
            nxt[wa] = wd;
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d wa=%0d wd=%h expected=none", cyc, wa, wd);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                if (wa !== e.wa || wd !== e.wd || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write actual cyc=%0d wa=%0d wd=%h expected cyc=%0d wa=%0d wd=%h",
                             cyc, wa, wd, e.cyc, e.wa, e.wd);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cyc=%0d expected=none", cyc);
            end else begin
                int ec;
                ec = dq.pop_front();
                if (cyc != ec) begin
                    failures++;
                    $display("FAIL done_cycle actual=%0d expected=%0d", cyc, ec);
                end
            end
        end
    end

    task automatic clear_rows();
        for (int i = 0; i < 8; i++) begin
            board[i] = 8'h00;
            expv[i]  = 8'h00;
        end
    endtask

    // Launch one generation from cycle 0; hold keeps start high through cycle 9.
    task automatic run_gen(input bit hold);
        int t0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        for (int r = 1; r < 8; r++)
            wq.push_back('{cyc: t0 + r + 2, wa: 3'(r), wd: expv[r]});
        dq.push_back(t0 + 10);
        exp_gen++;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (!hold || k >= 10) start = 1'b0;
            chk($sformatf("busy_c%0d", k), 32'(busy), 32'((k >= 1 && k <= 9) ? 1 : 0));
        end
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("done_queue_drained", 32'(dq.size()), 32'd0);
        chk("gen_count", 32'(gen_count), 32'(exp_gen));
    endtask

    initial begin
        clear_rows();
        for (int i = 0; i < 8; i++) nxt[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_wa", 32'(wa), 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gen_count", 32'(gen_count), 32'd0);
        chk("rst_ra", 32'(ra), 32'd0);
        reset = 1'b0;

        // Empty board
        clear_rows();
        run_gen(1'b0);

        // Blinker, two generations
        clear_rows();
        board[3] = 8'h1C;
        expv[2] = 8'h08; expv[3] = 8'h08; expv[4] = 8'h08;
        run_gen(1'b0);
        for (int i = 1; i < 8; i++) board[i] = nxt[i];
        for (int i = 0; i < 8; i++) expv[i] = 8'h00;
        expv[3] = 8'h1C;
        run_gen(1'b0);

        // Block still life in the top rows at column 0
        clear_rows();
        board[1] = 8'h03; board[2] = 8'h03;
        expv[1]  = 8'h03; expv[2]  = 8'h03;
        run_gen(1'b0);

        // Bottom border row full
        clear_rows();
        board[7] = 8'hFF;
        expv[6]  = 8'h7E; expv[7] = 8'h7E;
        run_gen(1'b0);

        // start held high while busy: still exactly one generation
        clear_rows();
        board[3] = 8'h1C;
        expv[2] = 8'h08; expv[3] = 8'h08; expv[4] = 8'h08;
        run_gen(1'b1);

        // Reset in cycle 5 aborts the generation
        begin
            int t0;
            clear_rows();
            @(negedge clk);
            start = 1'b1;
            t0 = cyc;
            for (int r = 1; r <= 3; r++)
                wq.push_back('{cyc: t0 + r + 2, wa: 3'(r), wd: 8'h00});
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (k == 5) reset = 1'b1;
            end
            @(negedge clk);
            reset = 1'b0;
            chk("abort_regwrite", 32'(regwrite), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_gen_count", 32'(gen_count), 32'd0);
            chk("abort_wa", 32'(wa), 32'd0);
            chk("abort_wd", 32'(wd), 32'd0);
            repeat (8) @(negedge clk);
            chk("abort_idle_busy", 32'(busy), 32'd0);
            chk("abort_queue_drained", 32'(wq.size()), 32'd0);
            exp_gen = 0;
        end

        // Fresh start after the abort completes normally
        clear_rows();
        board[1] = 8'h03; board[2] = 8'h03;
        expv[1]  = 8'h03; expv[2]  = 8'h03;
        run_gen(1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gol_row_stepper.md
# gol_row_stepper

Sequencer and Life-rule evaluator that computes one Game of Life generation. It sits directly downstream of the current-state register file: it drives that file's read address, consumes its combinational read data one row per cycle, and writes each next-generation row into the next-state register file through an identical write port (`regwrite`/`wa`/`wd`). It uses the register file's hardwired-zero row 0 as the dead top border.

## Interface
- `WIDTH`, 8: cells per row (row word width)
- `REGBITS`, 3: row address bits; N = 2**REGBITS, live board rows 1..N-1
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: request one generation; sampled only in IDLE
- `ra` out REGBITS: read address to the current-state regfile (combinational from state)
- `rd` in WIDTH: read data from the current-state regfile (combinational, same cycle)
- `regwrite` out 1: write enable to the next-state regfile (registered)
- `wa` out REGBITS: write address (registered)
- `wd` out WIDTH: next-generation row data (registered)
- `busy` out 1: high in FILL/RUN/FLUSH
- `done` out 1: one-cycle pulse in DONE
- `gen_count` out 16: completed generations, wraps at 2**16

## Operation
- Cell rule per column c: n = live count of 8 neighbours from rows prev/cur/next, columns c-1..c+1. Columns -1 and WIDTH are dead; no horizontal wrap. n is 4 bits (0..8). next[c] = (n==3) | (cur[c] & n==2).
- Window registers `prev`, `cur` (WIDTH each); the next row is `rd` in the current cycle.
- Row counter r (REGBITS).
- States: IDLE, FILL, RUN, FLUSH, DONE.
  - IDLE: ra=0. If start=1: prev<=0, go to FILL. Otherwise stay.
  - FILL: ra=1; cur<=rd; r<=1; go to RUN.
  - RUN: ra=r+1 mod N, so row N-1 reads address 0 and gets the zero bottom border. On the edge: regwrite<=1, wa<=r, wd<=rule(prev,cur,rd); prev<=cur; cur<=rd. If r==N-1 go to FLUSH, else r<=r+1.
  - FLUSH: ra=0; regwrite<=0; go to DONE.
  - DONE: done=1; gen_count<=gen_count+1; go to IDLE.
- `regwrite` is registered and low in every cycle not following a RUN cycle.
- Row 0 is never written.
- start is ignored outside IDLE; no queuing. start held high relaunches after DONE→IDLE.
- The current-state file is read-only to this block; copy-back/swap is outside its scope.

## Timing
- Reset (any state, including mid-generation): next cycle state=IDLE, regwrite=0, wa=0, wd=0, busy=0, done=0, gen_count=0, prev=cur=0, r=0. No further writes of an aborted generation.
- Cycle numbering: start sampled at edge ending cycle 0.
  - FILL in cycle 1.
  - RUN for row r in cycle r+1 (cycles 2..N).
  - FLUSH in cycle N+1.
  - DONE in cycle N+2.
  - IDLE from cycle N+3; next start accepted there.
- The write for row r is presented (regwrite=1, wa=r, wd valid) throughout cycle r+2, i.e. cycles 3..N+1, exactly N-1 writes. The address/data are stable for the whole cycle, satisfying the regfile's ph2 latch.
- For N=8: writes in cycles 3..9; done in cycle 10; busy in cycles 1..9.
- rd is sampled at the end of the same cycle ra is driven, with zero added latency.

## Test plan
- Empty board, start pulse: writes rows 1..7 with wd=0x00 in cycles 3..9, done in cycle 10, gen_count=1.
- Blinker: row3=0x1C, others 0 -> rows 2,3,4 = 0x08, rest 0x00. A second generation restores row3=0x1C; gen_count=2.
- Block still life at the top-right corner: rows1,2=0x03 -> rows1,2=0x03 unchanged. Covers row-0 border and column-0 boundary.
- Bottom/edge border: row7=0xFF only -> row6=0x7E, row7=0x7E, rows1..5=0x00.
- start asserted again in cycles 2..9: ignored, exactly 7 writes, one done.
- reset asserted in cycle 5: IDLE, regwrite=0 in cycle 6 onward, gen_count=0, no done. A fresh start then completes normally.
